// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register target.
package sccb_pkg;

    localparam int unsigned BitCntW  = 3;
    localparam int unsigned RegAddrW = 16;
    localparam int unsigned DataW    = 8;

    // Bus level seen on SDA during an acknowledge slot
    localparam logic AckLevel  = 1'b0;
    localparam logic NackLevel = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StDev,
        StAckDev,
        StAddrH,
        StAckH,
        StAddrL,
        StAckL,
        StWdata,
        StAckW,
        StRdata,
        StAckR,
        StWaitStop
    } state_e;

endpackage

// File: rtl/sccb_reg_target_if.sv
// Pad and register-file signals of the SCCB register target.
interface sccb_reg_target_if;
    import sccb_pkg::*;

    logic                scl_i;
    logic                sda_i;
    logic                sda_oe;
    logic                wr_en;
    logic [RegAddrW-1:0] wr_addr;
    logic [DataW-1:0]    wr_data;
    logic [RegAddrW-1:0] rd_addr;
    logic [DataW-1:0]    rd_data;
    logic                busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );

endinterface

// File: rtl/sccb_line_sync.sv
// Synchronises SCL/SDA and detects SCL edges plus START/STOP conditions.
module sccb_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s;

    // Synchroniser chains and previous-value registers; reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda       = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // SDA edges only count as START/STOP while SCL is stable high
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/sccb_reg_target.sv
// SCCB/I2C register target: 16-bit register address, 8-bit data, write strobes to a
// register file. Define SCCB_READ_EN to include the combined-format read path.
module sccb_reg_target
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR    = 8'h78,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sccb_reg_target_if.slave  bus
);

`ifdef SCCB_READ_EN
    localparam logic [7:0] DevAddrRd = DEV_ADDR | 8'h01;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^bus.rd_data;
`endif

    logic scl_rise, scl_fall, start_det, stop_det, sda;

    state_e              state_q, state_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DataW-1:0]    shift_q, shift_d;
    logic [RegAddrW-1:0] ptr_q, ptr_d;
    logic                phase_q, phase_d;
    logic                rd_sel_q, rd_sel_d;
    logic                sda_oe_q, sda_oe_d;
    logic                wr_en_q, wr_en_d;
    logic [RegAddrW-1:0] wr_addr_q, wr_addr_d;
    logic [DataW-1:0]    wr_data_q, wr_data_d;
    logic [DataW-1:0]    byte_in;
    logic                last_bit;

    sccb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda       (sda)
    );

    assign byte_in  = {shift_q[DataW-2:0], sda};
    assign last_bit = scl_rise && (bit_cnt_q == 3'd7);

    // Next-state logic; phase_q marks that the first SCL fall of an ACK slot has passed
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        phase_d   = phase_q;
        rd_sel_d  = rd_sel_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (start_det) begin
            state_d   = StDev;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                StDev, StAddrH, StAddrL, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (last_bit) begin
                        phase_d = 1'b0;
                        case (state_q)
                            StDev: begin
                                if (byte_in == DEV_ADDR) begin
                                    rd_sel_d = 1'b0;
                                    state_d  = StAckDev;
`ifdef SCCB_READ_EN
                                end else if (byte_in == DevAddrRd) begin
                                    rd_sel_d = 1'b1;
                                    state_d  = StAckDev;
`endif
                                end else begin
                                    state_d = StWaitStop;
                                end
                            end
                            StAddrH: begin
                                ptr_d[15:8] = byte_in;
                                state_d     = StAckH;
                            end
                            StAddrL: begin
                                ptr_d[7:0] = byte_in;
                                state_d    = StAckL;
                            end
                            default: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_in;
                                state_d   = StAckW;
                            end
                        endcase
                    end
                end
                StAckDev, StAckH, StAckL, StAckW: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d  = 1'b1;
                            sda_oe_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            case (state_q)
                                StAckDev: begin
                                    if (rd_sel_q) begin
`ifdef SCCB_READ_EN
                                        state_d  = StRdata;
                                        shift_d  = bus.rd_data;
                                        sda_oe_d = ~bus.rd_data[7];
`else
                                        state_d  = StWaitStop;
`endif
                                    end else begin
                                        state_d = StAddrH;
                                    end
                                end
                                StAckH:  state_d = StAddrL;
                                default: begin
                                    // Both the address-low ACK and a data ACK lead to data
                                    if (state_q == StAckW) ptr_d = ptr_q + 16'd1;
                                    state_d = StWdata;
                                end
                            endcase
                        end
                    end
                end
`ifdef SCCB_READ_EN
                StRdata: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            state_d = StAckR;
                        end
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[DataW-2:0], 1'b0};
                        sda_oe_d = ~shift_q[DataW-2];
                    end
                end
                StAckR: begin
                    if (scl_fall && !phase_q) begin
                        phase_d  = 1'b1;
                        sda_oe_d = 1'b0;
                    end else if (scl_rise && phase_q) begin
                        if (sda == NackLevel) state_d = StWaitStop;
                        else                  ptr_d   = ptr_q + 16'd1;
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StRdata;
                        shift_d   = bus.rd_data;
                        sda_oe_d  = ~bus.rd_data[7];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // State registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            phase_q   <= 1'b0;
            rd_sel_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            phase_q   <= phase_d;
            rd_sel_q  <= rd_sel_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_addr = ptr_q;
    assign bus.busy    = (state_q != StIdle);

endmodule

// File: doc/sccb_reg_target.md
# sccb_reg_target

Clocked SCCB/I2C register target with 16-bit register addresses and 8-bit data. It models the camera side of the configuration bus that the sensor-init sequencer drives. It decodes `{dev_addr, reg_addr[15:8], reg_addr[7:0], data...}` write transactions and combined-format reads, and presents each written byte as a one-cycle strobe to a register file. It sits between the SCCB pads and a register-array model, and is used in simulation and on-board loopback to check init-table playback.

## Interface
- `DEV_ADDR`, default 8'h78: 8-bit write address. The read address is DEV_ADDR|1.
- `SYNC_STAGES`, default 2: synchroniser depth on SCL/SDA, minimum 2.
- `clk` in 1: system clock. Must be ≥ 8× SCL frequency.
- `rst_n` in 1: reset, asynchronous, active-low.
- `scl_i` in 1: SCL pad input.
- `sda_i` in 1: SDA pad input.
- `sda_oe` out 1: 1 = pull SDA low. SDA is open-drain; the block never drives high.
- `wr_en` out 1: one-cycle write strobe.
- `wr_addr` out 16: register address for `wr_en`.
- `wr_data` out 8: data for `wr_en`.
- `rd_addr` out 16: current read address, always equal to the internal address pointer.
- `rd_data` in 8: register contents at `rd_addr`, valid combinationally.
- `busy` out 1: high from START until STOP or abort.

## Operation
- The SCL and SDA inputs are synchronised. Edges are detected on the synchronised signals.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- Bits are sampled on the SCL rising edge, MSB first. `sda_oe` changes only on the SCL falling edge.
- FSM states: IDLE, DEV, ACK_DEV, ADDR_H, ACK_H, ADDR_L, ACK_L, WDATA, ACK_W, RDATA, ACK_R, WAIT_STOP.
- IDLE → DEV on START.
- DEV, after 8 bits:
  - byte == DEV_ADDR → ACK_DEV, then ADDR_H.
  - byte == DEV_ADDR|1 → ACK_DEV, then RDATA.
  - any other byte → no ACK, go to WAIT_STOP.
- ADDR_H loads ptr[15:8]. ADDR_L loads ptr[7:0]. Each address byte is ACKed.
- WDATA, after 8 bits:
  - pulse `wr_en` with `wr_addr` = ptr and `wr_data` = byte.
  - ACK the byte, then increment ptr.
  - return to WDATA for the next byte.
- ptr increments modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- RDATA:
  - `rd_data` is captured into the shift register on the SCL falling edge that ends the preceding ACK.
  - Each bit is driven as `sda_oe` = ~bit.
  - After 8 bits, SDA is released and the state goes to ACK_R.
- ACK_R samples the master's acknowledge:
  - 0 (ACK): increment ptr and return to RDATA.
  - 1 (NACK): go to WAIT_STOP.
- A repeated START in any state resets the bit counter and goes to DEV. ptr is retained, which supports the combined write-address / Sr / read format.
- STOP in any state goes to IDLE. A partial byte is discarded and no `wr_en` is issued.

## Timing
- Reset values: `sda_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, FSM=IDLE, ptr=0.
- Reset asserted mid-transfer forces `sda_oe`=0 asynchronously.
- Edge-detect latency: SYNC_STAGES+1 clk from the pad edge to the internal event.
- `wr_en` asserts exactly 1 clk after the internal rising-edge event of the 8th WDATA bit. `wr_addr`/`wr_data` are held until the next strobe.
- ACK drive: `sda_oe`=1 from the internal SCL-fall event after bit 8 until the next internal SCL-fall event.
- Only one `wr_en` is issued per byte. No back-to-back strobes are possible, because the minimum spacing is 9 SCL periods.
- If a START/STOP event and an SCL edge are detected in the same clk, START/STOP wins.

## Configuration
- `SCCB_READ_EN` defined: read path present (RDATA, ACK_R, `rd_data` capture).
- `SCCB_READ_EN` not defined:
  - DEV_ADDR|1 is NACKed and the FSM goes to WAIT_STOP.
  - `sda_oe` never asserts outside address/write ACKs.
  - `rd_data` is ignored.
  - `rd_addr` still tracks ptr.

## Structure
- Package `sccb_pkg` holds:
  - the FSM state enum;
  - bit-count width constant (3 bits);
  - ACK/NACK level constants;
  - register-address width (16) and data width (8).
- Sub-module `sccb_line_sync`: SYNC_STAGES flops per line plus a previous-value register. It outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det` and synchronised `sda`.

## Test plan
- Write 78 31 03 11 + STOP → one `wr_en` with `wr_addr`=16'h3103 and `wr_data`=8'h11. ACK on all three post-device bytes. `busy` falls after STOP.
- Burst 78 30 17 FF 7F → two strobes: (16'h3017, 8'hFF) then (16'h3018, 8'h7F).
- Wrong device 6C 30 08 82 → no ACK on any byte, `sda_oe` stays 0, no `wr_en`.
- Combined read: 78 30 0A, Sr, 79 with `rd_data`=8'h56 → SDA carries 0101_0110. The master NACKs, then STOP; `rd_addr` = 16'h300A throughout. Without `SCCB_READ_EN`, byte 79 is NACKed instead.
- Write 78 FF FF AA BB → strobes at 16'hFFFF then 16'h0000 (address wrap).
- STOP after 4 WDATA bits → no strobe, FSM=IDLE. Assert `rst_n`=0 during an ACK → `sda_oe`=0 in the same cycle.
